irb_scanout: RTL and testbench
==============================

IRB_SCANOUT -- requirements
Module: irb_scanout

Interface
REQ-001 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 IRB_RW  input  1  image-buffer write enable, active-low (0 = write).
REQ-004 IRB_A  input  6  write address, row-major {row[2:0],col[2:0]}.
REQ-005 IRB_D  input  8  write data.
REQ-006 done  input  1  controller frame-complete flag; level, stays high once asserted.
REQ-007 out_valid  output  1  scan-out byte valid.
REQ-008 out_ready  input  1  downstream accepts byte when out_valid&out_ready.
REQ-009 out_data  output  8  scan-out pixel.
REQ-010 out_last  output  1  high with pixel 63.
REQ-011 frame_sum  output  14  unsigned sum of all 64 pixels.
REQ-012 sum_valid  output  1  frame_sum final.
REQ-013 err  output  1  sticky frame error.

Function
REQ-014 Storage SHALL be 64x8 registers plus a 64-bit written-flag vector and a 7-bit unique-write counter.
REQ-015 States SHALL be CAPT, SCAN, FIN, ERR; reset state CAPT.
REQ-016 CAPT: on posedge with IRB_RW==0, mem[IRB_A]<=IRB_D and flag[IRB_A]<=1; counter increments only if the flag was 0 (rewrites of the same address overwrite data without counting).
REQ-017 Inputs IRB_A/IRB_D change on the negedge before the sampling posedge; the block SHALL sample on posedge only, with no negedge logic.
REQ-018 CAPT->SCAN when done==1 and counter==64 (including a final write in the same cycle); scan index<=0.
REQ-019 CAPT->ERR when done==1 and counter<64 after that cycle's write; err<=1.
REQ-020 SCAN: out_valid=1, out_data=mem[index], out_last=(index==63), all registered outputs, valid in the first SCAN cycle.
REQ-021 SCAN: on out_valid&out_ready, frame_sum<=frame_sum+out_data (14-bit, no overflow since 64*255=16320), index<=index+1; out_data/out_last SHALL be held stable while out_ready==0.
REQ-022 Handshake on index 63 -> FIN; out_valid<=0, out_last<=0, sum_valid<=1 in the next cycle.
REQ-023 Writes (IRB_RW==0) in SCAN, FIN or ERR SHALL NOT modify memory; in SCAN they set err<=1 (overrun), scan continues.
REQ-024 FIN/ERR: when done==0, go to CAPT, clearing flags, counter, index, frame_sum, sum_valid, err; memory contents are retained.
REQ-025 done falling during SCAN SHALL abort: ->CAPT with the same clearing, out_valid<=0 next cycle.
REQ-026 Throughput: one byte per cycle with out_ready held high; 64-byte scan in 64 cycles; sum_valid 1 cycle after the last handshake.

Reset
REQ-027 Reset SHALL force state CAPT, out_valid=0, out_data=0, out_last=0, frame_sum=0, sum_valid=0, err=0, counter=0, flags=0, index=0.
REQ-028 Reset asserted mid-SCAN SHALL drop out_valid immediately (asynchronous) and discard the frame.
REQ-029 Memory contents need not be reset.

Verification
REQ-030 Write A=0..63 with D=A, then done=1, out_ready=1 -> 64 bytes 0..63 on consecutive cycles, out_last on 63, frame_sum=2016, sum_valid=1, err=0.
REQ-031 Same frame with out_ready toggling 1,0,1,0 -> out_data held on stall cycles, byte order unchanged, frame_sum=2016.
REQ-032 Write 63 addresses (skip A=17), done=1 -> state ERR, err=1, out_valid never asserted.
REQ-033 Write A=5 twice (D=9, then D=200), with all others D=0 -> counter reaches 64 only after 64 unique addresses; scan shows 200 at index 5, frame_sum=200.
REQ-034 All D=255, write pulse at A=3 during SCAN -> err=1, scanned byte 3 =255, frame_sum=16320.
REQ-035 Reset pulse at scan index 30 -> out_valid=0 immediately, sum_valid=0; new full frame afterwards scans correctly from index 0.

Source files
------------

// File: rtl/irb_scanout.sv
// rtl/irb_scanout.sv - 8x8 image buffer capture and handshaked raster scan-out with frame sum
// Captures 64 unique pixel writes, then streams them out in address order while accumulating their sum.
module irb_scanout (
    input  logic        clk,
    input  logic        reset,
    input  logic        IRB_RW,
    input  logic [5:0]  IRB_A,
    input  logic [7:0]  IRB_D,
    input  logic        done,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic [13:0] frame_sum,
    output logic        sum_valid,
    output logic        err
);

    typedef enum logic [1:0] {CAPT, SCAN, FIN, ERR} state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  mem [64];
    logic [63:0] flags;
    logic [6:0]  count;
    logic [5:0]  index;

    logic        wr_capt;
    logic        new_addr;
    logic [6:0]  count_next;
    logic        handshake;
    logic        clear;
    logic [5:0]  index_inc;

    assign wr_capt    = (state == CAPT) && !IRB_RW;
    assign new_addr   = wr_capt && !flags[IRB_A];
    assign count_next = count + {6'd0, new_addr};
    assign handshake  = out_valid && out_ready;
    assign index_inc  = index + 6'd1;
    // Leaving FIN/ERR/SCAN back to capture discards the frame bookkeeping.
    assign clear      = (state != CAPT) && (state_next == CAPT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CAPT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CAPT: begin
                if (done) begin
                    state_next = (count_next == 7'd64) ? SCAN : ERR;
                end
            end
            SCAN: begin
                if (!done) begin
                    state_next = CAPT;
                end else if (handshake && (index == 6'd63)) begin
                    state_next = FIN;
                end
            end
            default: begin
                if (!done) begin
                    state_next = CAPT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_capt) begin
            mem[IRB_A] <= IRB_D;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= 8'd0;
            out_last  <= 1'b0;
            frame_sum <= 14'd0;
            sum_valid <= 1'b0;
            err       <= 1'b0;
            count     <= 7'd0;
            flags     <= 64'd0;
            index     <= 6'd0;
        end else if (clear) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_sum <= 14'd0;
            sum_valid <= 1'b0;
            err       <= 1'b0;
            count     <= 7'd0;
            flags     <= 64'd0;
            index     <= 6'd0;
        end else begin
            case (state)
                CAPT: begin
                    if (wr_capt) begin
                        flags[IRB_A] <= 1'b1;
                    end
                    count <= count_next;
                    if (state_next == SCAN) begin
                        index     <= 6'd0;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        // A final write to pixel 0 in the same cycle is not yet in mem.
                        out_data  <= (wr_capt && (IRB_A == 6'd0)) ? IRB_D : mem[0];
                    end
                    if (state_next == ERR) begin
                        err <= 1'b1;
                    end
                end
                SCAN: begin
                    if (!IRB_RW) begin
                        err <= 1'b1;
                    end
                    if (handshake) begin
                        frame_sum <= frame_sum + {6'd0, out_data};
                        if (index == 6'd63) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            sum_valid <= 1'b1;
                        end else begin
                            index    <= index_inc;
                            out_data <= mem[index_inc];
                            out_last <= (index_inc == 6'd63);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irb_scanout.sv
// tb/tb_irb_scanout.sv - directed and randomized self-checking bench for irb_scanout
module tb_irb_scanout;

    logic        clk = 1'b0;
    logic        reset;
    logic        IRB_RW;
    logic [5:0]  IRB_A;
    logic [7:0]  IRB_D;
    logic        done;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic [13:0] frame_sum;
    logic        sum_valid;
    logic        err;

    logic [7:0]  ref_mem [64];
    int          checks = 0;
    int          passes = 0;

    irb_scanout dut (
        .clk       (clk),
        .reset     (reset),
        .IRB_RW    (IRB_RW),
        .IRB_A     (IRB_A),
        .IRB_D     (IRB_D),
        .done      (done),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .frame_sum (frame_sum),
        .sum_valid (sum_valid),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        IRB_RW = 1'b0;
        IRB_A  = 6'(a);
        IRB_D  = 8'(d);
        ref_mem[a] = 8'(d);
    endtask

    // Random address order with extra rewrites; the last write is always a new address and carries done.
    task automatic rand_frame();
        int ord [64];
        for (int i = 0; i < 64; i++) ord[i] = i;
        for (int i = 63; i > 0; i--) begin
            int j = $urandom_range(0, i);
            int t = ord[i];
            ord[i] = ord[j];
            ord[j] = t;
        end
        for (int i = 0; i < 64; i++) begin
            if (i > 0 && ($urandom % 4) == 0) wr(ord[$urandom_range(0, i - 1)], $urandom);
            wr(ord[i], $urandom);
        end
        done = 1'b1;
    endtask

    // ready_mode: 0 always ready, 1 toggles 1,0,1,0, 2 random
    task automatic run_scan(input int ready_mode, input int inject_at, input int reset_at,
                            input int drop_at, input bit exp_err);
        int   exp_idx = 0;
        int   cyc = 0;
        int   total = 0;
        bit   stalled = 0;
        logic [7:0] prev_data = 8'd0;
        bit   r;
        for (int i = 0; i < 64; i++) total += ref_mem[i];
        while (exp_idx < 64 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (exp_idx == reset_at) begin
                reset = 1'b1;
                #1;
                chk("reset_valid", out_valid, 0);
                chk("reset_sum_valid", sum_valid, 0);
                chk("reset_sum", frame_sum, 0);
                #1;
                reset = 1'b0;
                done = 1'b0;
                out_ready = 1'b0;
                IRB_RW = 1'b1;
                return;
            end
            if (exp_idx == drop_at) begin
                done = 1'b0;
                out_ready = 1'b0;
                IRB_RW = 1'b1;
                @(negedge clk);
                chk("abort_valid", out_valid, 0);
                chk("abort_sum", frame_sum, 0);
                chk("abort_err", err, 0);
                return;
            end
            chk("scan_valid", out_valid, 1);
            chk("scan_data", out_data, ref_mem[exp_idx]);
            chk("scan_last", out_last, (exp_idx == 63) ? 1 : 0);
            if (stalled) chk("stall_hold", out_data, prev_data);
            IRB_RW = (cyc == inject_at) ? 1'b0 : 1'b1;
            IRB_A  = 6'd3;
            IRB_D  = 8'd0;
            case (ready_mode)
                0: r = 1'b1;
                1: r = cyc[0];
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            prev_data = ref_mem[exp_idx];
            if (r) exp_idx++;
            stalled = !r;
        end
        chk("scan_complete", exp_idx, 64);
        if (ready_mode == 0) chk("scan_cycles", cyc, 64);
        if (ready_mode == 1) chk("scan_cycles_toggle", cyc, 127);
        @(negedge clk);
        IRB_RW = 1'b1;
        out_ready = 1'b0;
        chk("fin_valid", out_valid, 0);
        chk("fin_last", out_last, 0);
        chk("fin_sum_valid", sum_valid, 1);
        chk("fin_sum", frame_sum, total);
        chk("fin_err", err, exp_err);
    endtask

    task automatic release_frame();
        @(negedge clk);
        done = 1'b0;
        IRB_RW = 1'b1;
        @(negedge clk);
        chk("rel_err", err, 0);
        chk("rel_sum_valid", sum_valid, 0);
        chk("rel_sum", frame_sum, 0);
        chk("rel_valid", out_valid, 0);
    endtask

    initial begin
        reset = 1'b1;
        IRB_RW = 1'b1;
        IRB_A = 6'd0;
        IRB_D = 8'd0;
        done = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_sum", frame_sum, 0);
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;

        // Ramp frame, full throughput
        for (int a = 0; a < 64; a++) wr(a, a);
        done = 1'b1;
        run_scan(0, -1, -1, -1, 0);
        chk("ramp_sum_2016", frame_sum, 2016);
        release_frame();

        // Ramp frame with ready toggling
        for (int a = 0; a < 64; a++) wr(a, a);
        done = 1'b1;
        run_scan(1, -1, -1, -1, 0);
        chk("toggle_sum_2016", frame_sum, 2016);
        release_frame();

        // All 255 with an overrun write aimed at pixel 3 mid-scan
        for (int a = 0; a < 64; a++) wr(a, 255);
        done = 1'b1;
        run_scan(0, 2, -1, -1, 1);
        chk("overrun_sum", frame_sum, 16320);
        release_frame();

        // Rewrites do not count toward 64: only 63 unique addresses -> error
        wr(5, 9);
        for (int a = 0; a < 63; a++) if (a != 5) wr(a, 0);
        wr(5, 200);
        done = 1'b1;
        @(negedge clk);
        IRB_RW = 1'b1;
        chk("dup_err", err, 1);
        chk("dup_valid", out_valid, 0);
        release_frame();

        // Rewrite of pixel 5 over a full frame of zeros
        wr(5, 9);
        for (int a = 0; a < 64; a++) if (a != 5) wr(a, 0);
        wr(5, 200);
        done = 1'b1;
        run_scan(0, -1, -1, -1, 0);
        chk("rewrite_sum", frame_sum, 200);
        release_frame();

        // Missing address 17 -> error, never valid
        for (int a = 0; a < 64; a++) if (a != 17) wr(a, a);
        @(negedge clk);
        IRB_RW = 1'b1;
        done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("skip_valid", out_valid, 0);
        end
        chk("skip_err", err, 1);
        chk("skip_sum_valid", sum_valid, 0);
        release_frame();

        // Random frames with random backpressure
        for (int k = 0; k < 3; k++) begin
            rand_frame();
            run_scan(2, -1, -1, -1, 0);
            release_frame();
        end

        // done falling mid-scan aborts; then a fresh frame
        rand_frame();
        run_scan(2, -1, -1, 20, 0);
        rand_frame();
        run_scan(0, -1, -1, -1, 0);
        release_frame();

        // Reset at scan index 30; then a fresh frame from index 0
        rand_frame();
        run_scan(0, -1, 30, -1, 0);
        @(negedge clk);
        rand_frame();
        run_scan(2, -1, -1, -1, 0);
        release_frame();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
